ktms_afu_mmio_perfcnt: RTL and testbench



---
 rtl/ktms_afu_mmio_perfcnt.sv | 186 ++++++++++++++++++
 tb/tb_ktms_afu_mmio_perfcnt.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ktms_afu_mmio_perfcnt.sv
// ktms_afu_mmio_perfcnt
// Bank of MMIO-readable/writable event counters for the AFU, with a control
// register holding a freeze bit and a self-clearing clear-all bit.
// The block decodes the raw MMIO command bus and returns exactly one
// valid/data pulse per accepted access (reads and writes alike), one cycle
// after the command. Data is zero whenever valid is low so the result can be
// OR-combined with other responders.
//
// Bus bit numbering: the MMIO buses use big-endian bit naming, so bit 0 is
// the MSB. In this file all vectors are declared [N-1:0], which means
//   IBM bit 63 (LSB)      == bit 0 here
//   IBM bits [0:31]       == bits [63:32] here (selected by an even address)
//   IBM bits [32:63]      == bits [31:0]  here (selected by an odd address)
// Control register: freeze is IBM bit 63 (bit 0 here), clear-all is IBM
// bit 62 (bit 1 here).
//
// Optional build macro: KTMS_PERFCNT_CLR_ON_RD_EN
//   defined   -> a 64-bit (dw=1) read of a counter also clears it; an
//                increment arriving in the same cycle is kept (counter = 1)
//   undefined -> reads never change state

module ktms_afu_mmio_perfcnt #(
    parameter int          mmiobus_awidth  = 28,
    parameter int          mmio_addr_width = 24,
    parameter int          ncnt            = 8,
    parameter int          cnt_width       = 48,
    parameter int unsigned base_addr       = 'h804800
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [mmiobus_awidth-1:0] i_mmioabus,
    input  logic [63:0]               i_mmiodbus,
    input  logic [ncnt-1:0]           i_inc,
    output logic                      o_mmio_v,
    output logic [63:0]               o_mmio_d,
    output logic                      o_frozen
);

    // Register index width: counters 0..ncnt-1 plus the control register at ncnt
    localparam int IDXW = $clog2(ncnt + 1);

    // Inclusive word-address window covered by this block
    localparam logic [mmio_addr_width-1:0] WIN_LO = mmio_addr_width'(base_addr);
    localparam logic [mmio_addr_width-1:0] WIN_HI = mmio_addr_width'(base_addr + 2 * ncnt + 1);
    localparam logic [IDXW-1:0]            CTRL_IDX = IDXW'(ncnt);

    // Command fields
    logic                       cmdVld;
    logic                       cmdCfg;
    logic                       cmdRnw;
    logic                       cmdDw;
    logic [mmio_addr_width-1:0] cmdAddr;

    // Decode results
    logic            hit;
    logic            isCtrl;
    logic            hiHalf;
    logic [IDXW-1:0] regIdx;
    logic            wrEn;
    logic            ctrlWr;
    logic            clearAll;

    // Datapath
    logic [63:0] selView;
    logic [63:0] rdData;
    logic [63:0] wrView;

    // State
    logic [cnt_width-1:0] cnt_q [ncnt];
    logic [cnt_width-1:0] cnt_d [ncnt];
    logic                 freeze_q;
    logic                 freeze_d;
    logic                 mmioV_q;
    logic                 mmioV_d;
    logic [63:0]          mmioD_q;
    logic [63:0]          mmioD_d;

    // Split the command bus into its fields; vld is the most significant bit
    always_comb begin
        cmdVld  = i_mmioabus[mmiobus_awidth-1];
        cmdCfg  = i_mmioabus[mmiobus_awidth-2];
        cmdRnw  = i_mmioabus[mmiobus_awidth-3];
        cmdDw   = i_mmioabus[mmiobus_awidth-4];
        cmdAddr = i_mmioabus[mmio_addr_width-1:0];
    end

    // Address decode: window hit, register index (word pair), and half select
    always_comb begin
        hit      = cmdVld & ~cmdCfg & (cmdAddr >= WIN_LO) & (cmdAddr <= WIN_HI);
        regIdx   = IDXW'((cmdAddr - WIN_LO) >> 1);
        isCtrl   = (regIdx == CTRL_IDX);
        hiHalf   = ~cmdAddr[0];
        wrEn     = hit & ~cmdRnw;
        ctrlWr   = wrEn & isCtrl;
    end

    // 64-bit view of the addressed register as it stands this cycle
    always_comb begin
        selView = '0;
        if (isCtrl) begin
            selView = {63'd0, freeze_q};
        end else begin
            for (int k = 0; k < ncnt; k++) begin
                if (regIdx == IDXW'(k)) begin
                    selView = 64'(cnt_q[k]);
                end
            end
        end
    end

    // Read data formatting and write-merge: a 32-bit access replicates the
    // selected half on reads and replaces only that half on writes
    always_comb begin
        if (cmdDw) begin
            rdData = selView;
            wrView = i_mmiodbus;
        end else if (hiHalf) begin
            rdData = {2{selView[63:32]}};
            wrView = {i_mmiodbus[31:0], selView[31:0]};
        end else begin
            rdData = {2{selView[31:0]}};
            wrView = {selView[63:32], i_mmiodbus[31:0]};
        end
    end

    // Control register next state; clear-all is a pulse, never stored
    always_comb begin
        clearAll = ctrlWr & wrView[1];
        freeze_d = ctrlWr ? wrView[0] : freeze_q;
    end

    // Counter next state, priority: clear-all, MMIO write, (clear-on-read), increment
    always_comb begin
        for (int k = 0; k < ncnt; k++) begin
            logic sel;
            logic incOk;
            cnt_d[k] = cnt_q[k];
            sel      = hit & ~isCtrl & (regIdx == IDXW'(k));
            incOk    = i_inc[k] & ~freeze_q;
            if (clearAll) begin
                cnt_d[k] = '0;
            end else if (sel & ~cmdRnw) begin
                cnt_d[k] = wrView[cnt_width-1:0];
`ifdef KTMS_PERFCNT_CLR_ON_RD_EN
            end else if (sel & cmdRnw & cmdDw) begin
                cnt_d[k] = incOk ? cnt_width'(1) : '0;
`endif
            end else if (incOk) begin
                cnt_d[k] = cnt_q[k] + cnt_width'(1);
            end
        end
    end

    // Response next state: one pulse per hit, data only for reads
    always_comb begin
        mmioV_d = hit;
        mmioD_d = (hit & cmdRnw) ? rdData : 64'd0;
    end

    // State registers; reset overrides any command or increment in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < ncnt; k++) begin
                cnt_q[k] <= '0;
            end
            freeze_q <= 1'b0;
            mmioV_q  <= 1'b0;
            mmioD_q  <= 64'd0;
        end else begin
            for (int k = 0; k < ncnt; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            freeze_q <= freeze_d;
            mmioV_q  <= mmioV_d;
            mmioD_q  <= mmioD_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        o_mmio_v = mmioV_q;
        o_mmio_d = mmioD_q;
        o_frozen = freeze_q;
    end

endmodule

// File: tb/tb_ktms_afu_mmio_perfcnt.sv
// tb_ktms_afu_mmio_perfcnt
// Directed self-checking bench for the MMIO performance counter bank,
// default parameters (8 counters x 48 bits at word address 'h804800).
// Honours KTMS_PERFCNT_CLR_ON_RD_EN for the clear-on-read expectation.

module tb_ktms_afu_mmio_perfcnt;

    localparam logic [23:0] BASE = 24'h804800;
    localparam logic [23:0] CTRL = BASE + 24'd16;

    logic        clk;
    logic        reset;
    logic [27:0] abus;
    logic [63:0] dbus;
    logic [7:0]  inc;
    logic        mmioV;
    logic [63:0] mmioD;
    logic        frozen;

    int total;
    int bad;

    ktms_afu_mmio_perfcnt dut (
        .clk        (clk),
        .reset      (reset),
        .i_mmioabus (abus),
        .i_mmiodbus (dbus),
        .i_inc      (inc),
        .o_mmio_v   (mmioV),
        .o_mmio_d   (mmioD),
        .o_frozen   (frozen)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a command word {vld, cfg, rnw, dw, addr}
    function automatic logic [27:0] mkCmd(input logic vld, input logic cfg,
                                          input logic rnw, input logic dw,
                                          input logic [23:0] addr);
        return {vld, cfg, rnw, dw, addr};
    endfunction

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs starting 1 ns after an edge; return 1 ns after
    // the next edge so the response to this cycle is visible, with inputs idle
    task automatic applyStimulus(input logic [27:0] cmd, input logic [63:0] data,
                                 input logic [7:0] incMask);
        abus = cmd;
        dbus = data;
        inc  = incMask;
        @(posedge clk);
        #1;
        abus = '0;
        dbus = '0;
        inc  = '0;
    endtask

    task automatic readReg(input string tag, input logic [23:0] addr, input logic dw,
                           input logic [7:0] incMask, input logic [63:0] expected);
        applyStimulus(mkCmd(1'b1, 1'b0, 1'b1, dw, addr), 64'd0, incMask);
        checkOutput({tag, "_v"}, {63'd0, mmioV}, 64'd1);
        checkOutput(tag, mmioD, expected);
    endtask

    task automatic writeReg(input string tag, input logic [23:0] addr, input logic dw,
                            input logic [63:0] data, input logic [7:0] incMask);
        applyStimulus(mkCmd(1'b1, 1'b0, 1'b0, dw, addr), data, incMask);
        checkOutput({tag, "_v"}, {63'd0, mmioV}, 64'd1);
        checkOutput({tag, "_d"}, mmioD, 64'd0);
    endtask

    task automatic noResponse(input string tag, input logic [27:0] cmd,
                              input logic [63:0] data);
        applyStimulus(cmd, data, 8'd0);
        checkOutput({tag, "_v"}, {63'd0, mmioV}, 64'd0);
        checkOutput({tag, "_d"}, mmioD, 64'd0);
    endtask

    task automatic pulseInc(input logic [7:0] incMask, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus('0, 64'd0, incMask);
        end
    endtask

    // Main directed sequence
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        abus  = '0;
        dbus  = '0;
        inc   = '0;
        @(posedge clk);
        #1;

        // Reset: a command and increments in a reset cycle are ignored
        applyStimulus(mkCmd(1'b1, 1'b0, 1'b1, 1'b1, BASE), 64'd0, 8'hFF);
        checkOutput("rst_v", {63'd0, mmioV}, 64'd0);
        checkOutput("rst_d", mmioD, 64'd0);
        checkOutput("rst_frz", {63'd0, frozen}, 64'd0);
        reset = 1'b0;
        applyStimulus('0, 64'd0, 8'd0);
        checkOutput("rst_v2", {63'd0, mmioV}, 64'd0);

        // Five increments on counter 3, everything else still zero
        pulseInc(8'h08, 5);
        readReg("c3_five", BASE + 24'h6, 1'b1, 8'd0, 64'd5);
        for (int k = 0; k < 8; k++) begin
            if (k != 3) begin
                readReg($sformatf("c%0d_zero", k), BASE + 24'(2 * k), 1'b1, 8'd0, 64'd0);
            end
        end

        // Wrap of a 48-bit counter, plus 32-bit half reads
        writeReg("c0_wr", BASE, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 8'd0);
        readReg("c0_lo32", BASE + 24'h1, 1'b0, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        readReg("c0_hi32", BASE, 1'b0, 8'd0, 64'h0000_FFFF_0000_FFFF);
        pulseInc(8'h01, 1);
        readReg("c0_wrap", BASE, 1'b1, 8'd0, 64'd0);

        // Freeze: an increment in the same cycle as the freeze write still counts
        writeReg("frz_on", CTRL, 1'b1, 64'd1, 8'h02);
        checkOutput("frz_o", {63'd0, frozen}, 64'd1);
        pulseInc(8'h02, 10);
        readReg("c1_frozen", BASE + 24'h2, 1'b1, 8'd0, 64'd1);
        readReg("ctrl_rd", CTRL, 1'b1, 8'd0, 64'd1);
        readReg("ctrl_lo32", CTRL + 24'h1, 1'b0, 8'd0, 64'h0000_0001_0000_0001);
        writeReg("frz_off", CTRL, 1'b1, 64'd0, 8'd0);
        checkOutput("frz_o2", {63'd0, frozen}, 64'd0);
        pulseInc(8'h02, 2);
        readReg("c1_thaw", BASE + 24'h2, 1'b1, 8'd0, 64'd3);

        // Write beats a same-cycle increment
        writeReg("c2_wr", BASE + 24'h4, 1'b1, 64'd100, 8'h04);
        readReg("c2_100", BASE + 24'h4, 1'b1, 8'd0, 64'd100);

        // Clear-all beats increments, then a following write lands
        writeReg("clr", CTRL, 1'b1, 64'd2, 8'hFF);
        writeReg("c2_wr2", BASE + 24'h4, 1'b1, 64'd55, 8'd0);
        readReg("c2_55", BASE + 24'h4, 1'b1, 8'd0, 64'd55);
        readReg("c3_clr", BASE + 24'h6, 1'b1, 8'd0, 64'd0);
        readReg("c1_clr", BASE + 24'h2, 1'b1, 8'd0, 64'd0);
        readReg("ctrl_clr", CTRL, 1'b1, 8'd0, 64'd0);

        // 32-bit writes: low half, then high half truncated to 48 bits
        writeReg("c5_lo", BASE + 24'hB, 1'b0, 64'hDEAD_BEEF_1234_5678, 8'd0);
        writeReg("c5_hi", BASE + 24'hA, 1'b0, 64'h1111_2222_0001_FFFF, 8'd0);
        readReg("c5_rd", BASE + 24'hA, 1'b1, 8'd0, 64'h0000_FFFF_1234_5678);

        // No response and no side effect for cfg or out-of-window commands
        noResponse("cfg_rd", mkCmd(1'b1, 1'b1, 1'b1, 1'b1, BASE), 64'd0);
        noResponse("cfg_wr", mkCmd(1'b1, 1'b1, 1'b0, 1'b1, BASE), 64'd77);
        noResponse("oow_805000", mkCmd(1'b1, 1'b0, 1'b1, 1'b1, 24'h805000), 64'd0);
        noResponse("oow_above", mkCmd(1'b1, 1'b0, 1'b1, 1'b1, CTRL + 24'h2), 64'd0);
        noResponse("oow_below", mkCmd(1'b1, 1'b0, 1'b0, 1'b1, BASE - 24'h1), 64'd9);
        readReg("c0_nocfg", BASE, 1'b1, 8'd0, 64'd0);

        // Back-to-back reads give back-to-back pulses
        writeReg("c0_aa", BASE, 1'b1, 64'hAA, 8'd0);
        writeReg("c1_bb", BASE + 24'h2, 1'b1, 64'hBB, 8'd0);
        readReg("b2b_c0", BASE, 1'b1, 8'd0, 64'hAA);
        readReg("b2b_c1", BASE + 24'h2, 1'b1, 8'd0, 64'hBB);
        applyStimulus('0, 64'd0, 8'd0);
        checkOutput("b2b_idle_v", {63'd0, mmioV}, 64'd0);
        checkOutput("b2b_idle_d", mmioD, 64'd0);

        // Read with a same-cycle increment: clear-on-read keeps the event
        writeReg("c4_wr", BASE + 24'h8, 1'b1, 64'd7, 8'd0);
        readReg("c4_first", BASE + 24'h8, 1'b1, 8'h10, 64'd7);
`ifdef KTMS_PERFCNT_CLR_ON_RD_EN
        readReg("c4_second", BASE + 24'h8, 1'b1, 8'd0, 64'd1);
`else
        readReg("c4_second", BASE + 24'h8, 1'b1, 8'd0, 64'd8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
